// File: rtl/led_matrix_scan_ctrl_pkg.sv
// Shared types for the 8x8 LED matrix scan controller: frame storage layout,
// scan FSM states and the column-gather helper.
package led_matrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef logic [7:0] row_pat_t;
    typedef row_pat_t frame_t [ROWS];

    typedef enum logic {SCAN_BLANK, SCAN_DRIVE} scan_state_t;

    // Column pattern for scan row r: entry 0 of the frame lands on the MSB.
    function automatic row_pat_t column_of(input frame_t f, input logic [2:0] r);
        row_pat_t c;
        c = '0;
        for (int i = 0; i < ROWS; i++) begin
            c[COLS-1-i] = f[i][r];
        end
        return c;
    endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Bundle between a pattern producer (master) and the scan controller (slave):
// back-buffer write port, swap handshake and the matrix drive outputs.
interface led_matrix_scan_ctrl_if;
    import led_matrix_pkg::*;

    logic     wr_valid;
    logic     wr_ready;
    logic [2:0] wr_row;
    row_pat_t wr_data;
    logic     swap_req;
    logic     swap_ack;
    row_pat_t row;
    row_pat_t col;
    logic     frame_start;

    modport master (
        output wr_valid, wr_row, wr_data, swap_req,
        input  wr_ready, swap_ack, row, col, frame_start
    );

    modport slave (
        input  wr_valid, wr_row, wr_data, swap_req,
        output wr_ready, swap_ack, row, col, frame_start
    );

endinterface

// File: rtl/led_matrix_scan_ctrl_timer.sv
// Dwell counter for the scan FSM: counts cycles in the current state and flags
// the last one; the caller reloads it on every state change.
module led_scan_timer #(
    parameter int TICKS = 1,
    localparam int W = $clog2(TICKS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// 8x8 LED matrix scan controller: double-buffered frame store, blank/drive row
// scanning and frame-boundary bank swap.
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int DRIVE_TICKS = 27000,
    parameter int BLANK_TICKS = 270
) (
    input  logic                  clk,
    input  logic                  rst,
    led_matrix_scan_ctrl_if.slave bus
);

    localparam int MAX_TICKS = (DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    scan_state_t state, state_n;
    logic [2:0]  row_cnt, row_cnt_n;
    logic        front, front_n;
    logic        swap_pending, swap_pending_n;
    frame_t      bank [2];

    row_pat_t    row_q, row_n;
    row_pat_t    col_q, col_n;
    logic        swap_ack_q, swap_ack_n;
    logic        frame_start_q, frame_start_n;

    logic [TW-1:0] limit;
    logic          tmr_done;
    logic          wr_fire;

    led_scan_timer #(.TICKS(MAX_TICKS)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (tmr_done),
        .limit   (limit),
        .done    (tmr_done)
    );

    assign limit = (state == SCAN_BLANK) ? TW'(BLANK_TICKS - 1) : TW'(DRIVE_TICKS - 1);

    // The swap_ack cycle still counts as busy so the producer resumes one
    // cycle after it sees the acknowledge.
    assign bus.wr_ready    = !rst && !swap_pending && !swap_ack_q;
    assign wr_fire         = bus.wr_valid && bus.wr_ready;

    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.frame_start = frame_start_q;

    always_comb begin
        state_n        = state;
        row_cnt_n      = row_cnt;
        front_n        = front;
        swap_pending_n = swap_pending || bus.swap_req;
        swap_ack_n     = 1'b0;
        frame_start_n  = 1'b0;

        if (tmr_done) begin
            case (state)
                SCAN_BLANK: begin
                    state_n       = SCAN_DRIVE;
                    frame_start_n = (row_cnt == 3'd0);
                end
                SCAN_DRIVE: begin
                    state_n   = SCAN_BLANK;
                    row_cnt_n = row_cnt + 3'd1;
                    // A request arriving on the flip cycle opens the next swap
                    // rather than merging into the one completing now.
                    if (row_cnt == 3'd7 && swap_pending) begin
                        front_n        = !front;
                        swap_pending_n = bus.swap_req;
                        swap_ack_n     = 1'b1;
                    end
                end
                default: state_n = SCAN_BLANK;
            endcase
        end

        row_n = '0;
        col_n = '0;
        if (state_n == SCAN_DRIVE) begin
            row_n = row_pat_t'(1) << row_cnt_n;
            col_n = column_of(bank[front_n], row_cnt_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SCAN_BLANK;
            row_cnt       <= 3'd0;
            front         <= 1'b0;
            swap_pending  <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank[b][r] <= '0;
                end
            end
        end else begin
            state         <= state_n;
            row_cnt       <= row_cnt_n;
            front         <= front_n;
            swap_pending  <= swap_pending_n;
            row_q         <= row_n;
            col_q         <= col_n;
            swap_ack_q    <= swap_ack_n;
            frame_start_q <= frame_start_n;
            if (wr_fire) begin
                bank[!front][bus.wr_row] <= bus.wr_data;
            end
        end
    end

endmodule
